// File: rtl/data_sram_resp.sv
// Data SRAM responder: word-organised memory with byte write enables, read-first
// semantics, a READ_LAT-deep return pipeline, access counters and a sticky range error.
module data_sram_resp #(
  parameter int unsigned ADDR_W   = 16,
  parameter logic [31:0] BASE     = 32'h0000_0000,
  parameter int unsigned READ_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt,
  output logic        addr_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned LAST  = READ_LAT - 1;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       offset;
  logic              in_range;
  logic [ADDR_W-1:0] widx;
  logic              acc;

  logic [READ_LAT-1:0] vld_p;
  logic [31:0]         data_p [READ_LAT];
  logic [31:0]         rdata_hold;

  assign offset   = data_sram_addr - BASE;
  // Anything below BASE wraps to a huge offset and so lands out of range too.
  assign in_range = (offset >> (ADDR_W + 2)) == 32'd0;
  assign widx     = offset[ADDR_W+1:2];
  assign acc      = data_sram_en && !reset;

  // Stage p0 boundary: array write and read-first capture at the access edge.
  always_ff @(posedge clk) begin
    if (acc && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) mem[widx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    data_p[0] <= in_range ? mem[widx] : 32'h0;
    for (int i = 1; i < READ_LAT; i++) data_p[i] <= data_p[i-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= data_sram_en;
      for (int i = 1; i < READ_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Return boundary: the last stage drives rdata directly; the hold register
  // keeps it steady through bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_hold <= 32'h0;
    end else if (vld_p[LAST]) begin
      rdata_hold <= data_p[LAST];
    end
  end

  assign data_sram_rdata = vld_p[LAST] ? data_p[LAST] : rdata_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt   <= 32'd0;
      wr_cnt   <= 32'd0;
      addr_err <= 1'b0;
    end else if (data_sram_en) begin
      if (data_sram_wen == 4'h0) rd_cnt <= rd_cnt + 32'd1;
      else                       wr_cnt <= wr_cnt + 32'd1;
      if (!in_range) addr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp: three instances (latency 1, 3, 4) share one
// access stream; each step drives one edge and checks selected outputs after it.
module tb_data_sram_resp;

  localparam logic [31:0] B = 32'h0001_0000;

  logic        clk;
  logic        reset;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic [31:0] rdata_a, rd_a, wr_a;
  logic        err_a;
  logic [31:0] rdata_b, rd_b, wr_b;
  logic        err_b;
  logic [31:0] rdata_c, rd_c, wr_c;
  logic        err_c;

  int checks = 0;
  int errors = 0;

  data_sram_resp #(.ADDR_W(8), .BASE(B), .READ_LAT(1)) u_a (
    .clk(clk), .reset(reset), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata_a),
    .rd_cnt(rd_a), .wr_cnt(wr_a), .addr_err(err_a));

  data_sram_resp #(.ADDR_W(8), .BASE(B), .READ_LAT(3)) u_b (
    .clk(clk), .reset(reset), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata_b),
    .rd_cnt(rd_b), .wr_cnt(wr_b), .addr_err(err_b));

  data_sram_resp #(.ADDR_W(4), .BASE(B), .READ_LAT(4)) u_c (
    .clk(clk), .reset(reset), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata_c),
    .rd_cnt(rd_c), .wr_cnt(wr_c), .addr_err(err_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic e, input logic [3:0] w, input logic [31:0] a,
                      input logic [31:0] d);
    en = e; wen = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    idle();
    reset = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
    do_reset();
    chk("rst_rdata_a", rdata_a, 32'h0);
    chk("rst_rdata_b", rdata_b, 32'h0);
    chk("rst_rdata_c", rdata_c, 32'h0);
    chk("rst_rd_a", rd_a, 32'd0);
    chk("rst_wr_a", wr_a, 32'd0);
    chk("rst_err_a", 32'(err_a), 32'd0);

    // Latency 1: write then read back, counters.
    step(1'b1, 4'hF, B + 32'h10, 32'hDEAD_BEEF);
    chk("wr1_wr_cnt", wr_a, 32'd1);
    chk("wr1_rd_cnt", rd_a, 32'd0);
    step(1'b1, 4'h0, B + 32'h10, 32'h0);
    chk("rd_deadbeef", rdata_a, 32'hDEAD_BEEF);
    chk("rd1_rd_cnt", rd_a, 32'd1);
    chk("rd1_wr_cnt", wr_a, 32'd1);

    // Byte lanes.
    step(1'b1, 4'hF, B + 32'h20, 32'h1122_3344);
    step(1'b1, 4'b0101, B + 32'h20, 32'hAABB_CCDD);
    chk("lane_readfirst", rdata_a, 32'h1122_3344);
    step(1'b1, 4'h0, B + 32'h20, 32'h0);
    chk("lane_merge", rdata_a, 32'h11BB_33DD);

    // Read-first on a single write access, then read of the new value.
    step(1'b1, 4'hF, B + 32'h30, 32'h0000_0001);
    step(1'b1, 4'hF, B + 32'h30, 32'h0000_0002);
    chk("readfirst_old", rdata_a, 32'h0000_0001);
    step(1'b1, 4'h0, B + 32'h30, 32'h0);
    chk("readfirst_new", rdata_a, 32'h0000_0002);
    idle();
    chk("bubble_hold_a", rdata_a, 32'h0000_0002);
    chk("cnt_rd_a", rd_a, 32'd3);
    chk("cnt_wr_a", wr_a, 32'd5);

    // Latency 3: three back-to-back reads.
    step(1'b1, 4'hF, B + 32'h40, 32'd1);
    step(1'b1, 4'hF, B + 32'h44, 32'd2);
    step(1'b1, 4'hF, B + 32'h48, 32'd3);
    step(1'b1, 4'h0, B + 32'h40, 32'h0);
    chk("lat1_follow", rdata_a, 32'd1);
    step(1'b1, 4'h0, B + 32'h44, 32'h0);
    step(1'b1, 4'h0, B + 32'h48, 32'h0);
    chk("lat3_r1", rdata_b, 32'd1);
    idle();
    chk("lat3_r2", rdata_b, 32'd2);
    idle();
    chk("lat3_r3", rdata_b, 32'd3);
    idle();
    chk("lat3_hold", rdata_b, 32'd3);
    chk("err_c_pre", 32'(err_c), 32'd1);

    // Out-of-range on the 16-word instance; sticky until reset.
    do_reset();
    chk("rst2_err_c", 32'(err_c), 32'd0);
    chk("rst2_rd_c", rd_c, 32'd0);
    chk("rst2_wr_c", wr_c, 32'd0);
    step(1'b1, 4'hF, B + 32'h00, 32'hCAFE_0001);
    step(1'b1, 4'h0, B + 32'h00, 32'h0);
    step(1'b1, 4'h0, B + 32'h3C, 32'h0);
    chk("top_word_in_range", 32'(err_c), 32'd0);
    step(1'b1, 4'h0, B + 32'h40, 32'h0);
    chk("oor_err_c", 32'(err_c), 32'd1);
    chk("oor_rd_c", rd_c, 32'd3);
    chk("oor_wr_c", wr_c, 32'd1);
    chk("inrange_err_a", 32'(err_a), 32'd0);
    step(1'b1, 4'h0, B + 32'h00, 32'h0);
    chk("lat4_cafe", rdata_c, 32'hCAFE_0001);
    idle();
    idle();
    chk("oor_rdata_zero", rdata_c, 32'h0);
    idle();
    chk("lat4_cafe2", rdata_c, 32'hCAFE_0001);
    idle();
    chk("lat4_hold", rdata_c, 32'hCAFE_0001);
    chk("err_c_sticky", 32'(err_c), 32'd1);
    step(1'b1, 4'h0, B - 32'h4, 32'h0);
    chk("below_base_err_a", 32'(err_a), 32'd1);

    // Reset mid-flight with an access presented during reset.
    step(1'b1, 4'hF, B + 32'h08, 32'h5555_AAAA);
    step(1'b1, 4'h0, B + 32'h08, 32'h0);
    step(1'b1, 4'h0, B + 32'h00, 32'h0);
    reset = 1'b1;
    step(1'b1, 4'hF, B + 32'h08, 32'h0BAD_0BAD);
    reset = 1'b0;
    chk("mid_rst_rdata_c", rdata_c, 32'h0);
    chk("mid_rst_rd_c", rd_c, 32'd0);
    chk("mid_rst_wr_c", wr_c, 32'd0);
    chk("mid_rst_err_c", 32'(err_c), 32'd0);
    chk("mid_rst_err_a", 32'(err_a), 32'd0);
    idle();
    chk("discard1_c", rdata_c, 32'h0);
    idle();
    chk("discard2_c", rdata_c, 32'h0);
    idle();
    chk("discard3_c", rdata_c, 32'h0);
    chk("discard_rd_c", rd_c, 32'd0);
    step(1'b1, 4'h0, B + 32'h08, 32'h0);
    chk("post_rst_data_a", rdata_a, 32'h5555_AAAA);
    step(1'b1, 4'h0, B + 32'h00, 32'h0);
    chk("post_rst_cafe_a", rdata_a, 32'hCAFE_0001);
    idle();
    idle();
    chk("post_rst_data_c", rdata_c, 32'h5555_AAAA);
    chk("post_rst_rd_c", rd_c, 32'd2);
    chk("post_rst_wr_c", wr_c, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
# data_sram_resp

Responder end of the data SRAM interface driven by the execute stage: a synchronous, word-organised data memory with per-byte write enables and a configurable read-return latency. It accepts one access per cycle on `data_sram_*`, returns read data a fixed number of cycles later for the memory stage to consume, and keeps access counters plus a sticky out-of-range flag for bench and debug visibility.

## Interface
- `ADDR_W`, 16: word-address width; the array holds 2^ADDR_W 32-bit words.
- `BASE`, 32'h0000_0000: byte address of word 0; must be 2^(ADDR_W+2)-aligned.
- `READ_LAT`, 1: cycles from access edge to `data_sram_rdata` update; legal 1..4.
- `clk` in 1: single clock, all state on posedge.
- `reset` in 1: synchronous, active-high.
- `data_sram_en` in 1: access request, sampled at posedge.
- `data_sram_wen` in 4: byte write enables, lane i = bits [8i+7:8i]; 0 = read-only access.
- `data_sram_addr` in 32: byte address; bits [1:0] ignored.
- `data_sram_wdata` in 32: write data, lane-aligned.
- `data_sram_rdata` out 32: read data of the access issued READ_LAT cycles earlier.
- `rd_cnt` out 32: count of accepted accesses with wen == 0.
- `wr_cnt` out 32: count of accepted accesses with wen != 0.
- `addr_err` out 1: sticky, set by any enabled out-of-range access.

## Operation
- Access accepted on every posedge with `data_sram_en`=1 and `reset`=0; no back-pressure, no stall output.
- Offset = addr − BASE; in range iff offset < 2^(ADDR_W+2). Word index = offset[ADDR_W+1:2].
- In-range write: lanes with wen[i]=1 take wdata lane i; other lanes unchanged.
- Every accepted access (read or write) also reads the indexed word, read-first: the value before this edge's write. This read enters the return pipeline.
- Out-of-range access: array untouched; returned read value is 32'h0; `addr_err` set to 1 and held until reset; counters still increment.
- Return pipeline: READ_LAT stages, each {valid, data}. Stage 0 loads at the access edge; shifts every cycle. `data_sram_rdata` updates only when the last stage holds valid; otherwise it holds its previous value.
- `en`=0 cycles insert invalid bubbles; they never change `data_sram_rdata`.
- Counters are 32-bit, wrap from 32'hFFFF_FFFF to 0.
- Array contents are not initialised or cleared by reset.

## Timing
- Reset values: `data_sram_rdata`=0, `rd_cnt`=0, `wr_cnt`=0, `addr_err`=0; all pipeline valid bits cleared (in-flight reads discarded, no later update from them).
- Access at edge N (reset low): array write visible to any access at edge N+1 or later; read data appears on `data_sram_rdata` after edge N+READ_LAT−1... precisely: READ_LAT=1 → valid after edge N, i.e. during cycle N+1; in general after edge N+READ_LAT−1.
- Throughput: one access per cycle, back-to-back reads return in order, one per cycle.
- Write then read same word on consecutive edges: read returns new data. Same-edge read and write: read returns old data.
- Reset asserted with `en`=1 at the same edge: access ignored (no write, no count, no error).
- Counters and `addr_err` update at the access edge, visible the following cycle.

## Test plan
- READ_LAT=1: write 32'hDEAD_BEEF, wen=4'hF, addr=BASE+0x10; next cycle read same addr -> rdata=32'hDEAD_BEEF one cycle later; wr_cnt=1, rd_cnt=1.
- Byte lanes: word preset 32'h1122_3344; write wdata=32'hAABB_CCDD, wen=4'b0101 -> read returns 32'h11BB_33DD.
- Read-first: word holds 32'h0000_0001; single access wen=4'hF wdata=32'h0000_0002 -> returned data 32'h0000_0001; following read returns 32'h0000_0002.
- READ_LAT=3: reads of words holding 1,2,3 on three consecutive edges, then en=0 -> rdata 1,2,3 on cycles 3,4,5 after first edge, then holds 3.
- Out-of-range: ADDR_W=4, read addr=BASE+0x40 -> rdata 0, addr_err=1, stays 1 after further in-range accesses until reset.
- Reset mid-flight: READ_LAT=4, two reads issued, reset asserted one cycle later -> rdata=0, counters=0, addr_err=0, no later rdata change from discarded reads; array data written before reset still readable.
